seq_detect_param: RTL and testbench

Parametrised serial pattern detector for the lab I/O path. On a `load` strobe it captures a `DATA_W`-bit word from the board switches and shifts it out LSB first, one bit per clock. It compares a sliding window of the most recent `PAT_W` bits against a runtime-programmable pattern, in either overlapping or non-overlapping mode. It reports each match as a pulse, holds a sticky found flag for the LED, and keeps a saturating match count.

---
 rtl/seq_detect_pkg.sv | 19 +
 rtl/seq_detect_if.sv | 34 +++
 rtl/seq_window_cmp.sv | 67 ++++++
 rtl/seq_detect_param.sv | 137 +++++++++++++
 tb/tb_seq_detect_param.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/seq_detect_pkg.sv
// -----------------------------------------------------------------------------
// seq_detect_pkg
// Shared definitions for the serial pattern detector: the scan FSM state
// encoding and the default parameter values used by the interface, the
// window comparator and the top level.
// -----------------------------------------------------------------------------
package seq_detect_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_PAT_W  = 4;
    localparam int DEF_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_detect_if.sv
// -----------------------------------------------------------------------------
// seq_detect_if
// Control/status bundle of the pattern detector.
//   master : drives load, data_in, pattern, overlap
//            observes busy, hit, found, done, match_cnt
//   slave  : the detector itself (opposite directions)
// -----------------------------------------------------------------------------
interface seq_detect_if #(
    parameter int DATA_W = seq_detect_pkg::DEF_DATA_W,
    parameter int PAT_W  = seq_detect_pkg::DEF_PAT_W,
    parameter int CNT_W  = seq_detect_pkg::DEF_CNT_W
) ();

    logic              load;
    logic [DATA_W-1:0] data_in;
    logic [PAT_W-1:0]  pattern;
    logic              overlap;
    logic              busy;
    logic              hit;
    logic              found;
    logic              done;
    logic [CNT_W-1:0]  match_cnt;

    modport master (
        output load, data_in, pattern, overlap,
        input  busy, hit, found, done, match_cnt
    );

    modport slave (
        input  load, data_in, pattern, overlap,
        output busy, hit, found, done, match_cnt
    );

endinterface

// File: rtl/seq_window_cmp.sv
// -----------------------------------------------------------------------------
// seq_window_cmp
// Sliding window of the most recent PAT_W serial bits plus a saturating fill
// counter. `match` is combinational and reflects the window *after* the bit
// presented this cycle is shifted in, so the parent can register it as a
// one-cycle hit pulse on the same edge that consumes the bit.
//   clk, rst  : clock, asynchronous active-low reset
//   clear     : empty the window and fill counter (new scan)
//   shift_en  : consume bit_in this cycle
//   bit_in    : serial bit
//   pattern   : captured pattern, pattern[0] is the first serial bit
//   overlap   : 0 = restart filling after each match
//   match     : updated window is full and equals pattern
// -----------------------------------------------------------------------------
module seq_window_cmp
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             match
);

    localparam int              FILL_W   = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  win;
    logic [PAT_W-1:0]  win_next;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_inc;

    // Newest bit enters at the MSB so the oldest bit ends up in win[0],
    // lining up with pattern[0] being the first serial bit.
    assign win_next = {bit_in, win[PAT_W-1:1]};

    // NOTE: default assignment first, so every path drives fill_inc and no latch is inferred.
    always_comb begin
        fill_inc = fill;
        if (fill != FILL_MAX) begin
            fill_inc = fill + 1'b1;
        end
    end

    assign match = shift_en && (fill_inc == FILL_MAX) && (win_next == pattern);

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win  <= '0;
            fill <= '0;
        end else if (clear) begin
            win  <= '0;
            fill <= '0;
        end else if (shift_en) begin
            win  <= win_next;
            // Non-overlapping mode needs PAT_W fresh bits before the next match.
            fill <= (match && !overlap) ? '0 : fill_inc;
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
// Serial pattern detector. A load strobe captures a DATA_W-bit word, pattern
// and mode; the word is then shifted out LSB first, one bit per clock, through
// a PAT_W-bit sliding window compared against the pattern.
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   bus.load   : capture data_in/pattern/overlap and (re)start a scan
//   bus.busy   : scan in progress
//   bus.hit    : one-cycle pulse per match
//   bus.found  : sticky, at least one match since the last load
//   bus.done   : one-cycle pulse after the last bit has been examined
//   bus.match_cnt : saturating match count of the current/last scan
// Build option: define SEQ_DET_COUNT_EN to implement the match counter;
// without it match_cnt is tied to zero.
// -----------------------------------------------------------------------------
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int PAT_W  = DEF_PAT_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    seq_detect_if.slave  bus
);

    localparam int              BC_W     = $clog2(DATA_W + 1);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

    state_t            state;
    logic [DATA_W-1:0] sreg;
    logic [BC_W-1:0]   bit_cnt;
    logic [PAT_W-1:0]  pat_q;
    logic              ovl_q;
    logic              busy_q;
    logic              hit_q;
    logic              found_q;
    logic              done_q;
    logic              shift_en;
    logic              match;

    // A load in SHIFT aborts the scan, so no bit is consumed on that edge.
    assign shift_en = (state == SHIFT) && !bus.load;

    seq_window_cmp #(
        .PAT_W (PAT_W)
    ) u_win (
        .clk      (clk),
        .rst      (rst),
        .clear    (bus.load),
        .shift_en (shift_en),
        .bit_in   (sreg[0]),
        .pattern  (pat_q),
        .overlap  (ovl_q),
        .match    (match)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            sreg    <= '0;
            bit_cnt <= '0;
            pat_q   <= '0;
            ovl_q   <= 1'b0;
            busy_q  <= 1'b0;
            hit_q   <= 1'b0;
            found_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.load) begin
            state   <= SHIFT;
            sreg    <= bus.data_in;
            bit_cnt <= '0;
            pat_q   <= bus.pattern;
            ovl_q   <= bus.overlap;
            busy_q  <= 1'b1;
            hit_q   <= 1'b0;
            found_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // match is already gated by shift_en, so it is low outside SHIFT.
            hit_q  <= match;
            done_q <= 1'b0;
            if (match) begin
                found_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    busy_q <= 1'b0;
                end
                SHIFT: begin
                    sreg    <= sreg >> 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEQ_DET_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (bus.load) begin
            cnt_q <= '0;
        end else if (match && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.match_cnt = cnt_q;
`else
    assign bus.match_cnt = {CNT_W{1'b0}};
`endif

    assign bus.busy  = busy_q;
    assign bus.hit   = hit_q;
    assign bus.found = found_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_param
// Directed bench for seq_detect_param: a default-parameter instance (u_dut)
// and a PAT_W=2 / CNT_W=2 instance (u_sat) for counter saturation.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_seq_detect_param;

`ifdef SEQ_DET_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    seq_detect_if #(.DATA_W(8), .PAT_W(4), .CNT_W(4)) a_if ();
    seq_detect_if #(.DATA_W(8), .PAT_W(2), .CNT_W(2)) b_if ();

    seq_detect_param #(.DATA_W(8), .PAT_W(4), .CNT_W(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    seq_detect_param #(.DATA_W(8), .PAT_W(2), .CNT_W(2)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one load strobe to u_dut; returns at the falling edge after E0.
    task automatic start(input logic [7:0] d, input logic [3:0] p, input logic ovl);
        @(negedge clk);
        a_if.load    = 1'b1;
        a_if.data_in = d;
        a_if.pattern = p;
        a_if.overlap = ovl;
        @(negedge clk);
        a_if.load    = 1'b0;
    endtask

    // Observe 10 cycles following E0: hits[k] is hit after E(k+1).
    task automatic observe(output logic [7:0] hits, output int n_done,
                           output int done_at, output logic busy_at_done);
        hits         = '0;
        n_done       = 0;
        done_at      = -1;
        busy_at_done = 1'bx;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k < 8) hits[k] = a_if.hit;
            if (a_if.done) begin
                n_done++;
                done_at      = k;
                busy_at_done = a_if.busy;
            end
        end
    endtask

    logic [7:0] hits;
    int         n_done;
    int         done_at;
    logic       busy_at_done;
    int         n_hit;
    int         done_seen;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        a_if.load = 1'b0; a_if.data_in = '0; a_if.pattern = '0; a_if.overlap = 1'b0;
        b_if.load = 1'b0; b_if.data_in = '0; b_if.pattern = '0; b_if.overlap = 1'b0;

        // Reset state
        #12;
        check("rst_busy",  32'(a_if.busy),      32'd0);
        check("rst_hit",   32'(a_if.hit),       32'd0);
        check("rst_found", 32'(a_if.found),     32'd0);
        check("rst_done",  32'(a_if.done),      32'd0);
        check("rst_cnt",   32'(a_if.match_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // 1. Overlap: 1010 in AA -> hits on bits 3,5,7
        start(8'hAA, 4'b1010, 1'b1);
        check("t1_busy_after_load", 32'(a_if.busy), 32'd1);
        observe(hits, n_done, done_at, busy_at_done);
        check("t1_hits",      32'(hits),         32'h0000_00A8);
        check("t1_done_cnt",  32'(n_done),       32'd1);
        check("t1_done_at",   32'(done_at),      32'd7);
        check("t1_busy_done", 32'(busy_at_done), 32'd0);
        check("t1_found",     32'(a_if.found),   32'd1);
        check("t1_cnt",       32'(a_if.match_cnt), CNT_ON ? 32'd3 : 32'd0);

        // 2. Non-overlap: hits on bits 3,7 only
        start(8'hAA, 4'b1010, 1'b0);
        check("t2_found_cleared", 32'(a_if.found), 32'd0);
        observe(hits, n_done, done_at, busy_at_done);
        check("t2_hits",     32'(hits),           32'h0000_0088);
        check("t2_done_cnt", 32'(n_done),         32'd1);
        check("t2_cnt",      32'(a_if.match_cnt), CNT_ON ? 32'd2 : 32'd0);

        // 3. No match: 1111 in 0E
        start(8'h0E, 4'b1111, 1'b1);
        observe(hits, n_done, done_at, busy_at_done);
        check("t3_hits",     32'(hits),           32'd0);
        check("t3_found",    32'(a_if.found),     32'd0);
        check("t3_cnt",      32'(a_if.match_cnt), 32'd0);
        check("t3_done_cnt", 32'(n_done),         32'd1);
        check("t3_done_at",  32'(done_at),        32'd7);

        // 4. Abort after 3 bits, restart with FF / 1111 / overlap
        start(8'hAA, 4'b1010, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("t4_busy_mid", 32'(a_if.busy), 32'd1);
        start(8'hFF, 4'b1111, 1'b1);
        check("t4_found_restart", 32'(a_if.found), 32'd0);
        observe(hits, n_done, done_at, busy_at_done);
        check("t4_hits",     32'(hits),           32'h0000_00F8);
        check("t4_done_cnt", 32'(n_done),         32'd1);
        check("t4_done_at",  32'(done_at),        32'd7);
        check("t4_cnt",      32'(a_if.match_cnt), CNT_ON ? 32'd5 : 32'd0);

        // 5. Reset mid-scan: bit 3 matches, then reset asynchronously
        start(8'hAA, 4'b1010, 1'b1);
        repeat (4) @(negedge clk);
        check("t5_hit_before_rst",   32'(a_if.hit),   32'd1);
        check("t5_found_before_rst", 32'(a_if.found), 32'd1);
        #2;
        rst = 1'b0;
        a_if.load    = 1'b1;   // must be ignored while in reset
        a_if.data_in = 8'hFF;
        a_if.pattern = 4'b1111;
        #1;
        check("t5_busy_async",  32'(a_if.busy),      32'd0);
        check("t5_hit_async",   32'(a_if.hit),       32'd0);
        check("t5_found_async", 32'(a_if.found),     32'd0);
        check("t5_done_async",  32'(a_if.done),      32'd0);
        check("t5_cnt_async",   32'(a_if.match_cnt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        a_if.load = 1'b0;
        rst       = 1'b1;
        done_seen = 0;
        n_hit     = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (a_if.done) done_seen++;
            if (a_if.busy || a_if.hit) n_hit++;
        end
        check("t5_no_done",     32'(done_seen), 32'd0);
        check("t5_stays_idle",  32'(n_hit),     32'd0);

        // 6. Saturation on u_sat: FF / 11 / overlap -> 7 hits, count stops at 3
        @(negedge clk);
        b_if.load    = 1'b1;
        b_if.data_in = 8'hFF;
        b_if.pattern = 2'b11;
        b_if.overlap = 1'b1;
        @(negedge clk);
        b_if.load = 1'b0;
        n_hit     = 0;
        done_seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (b_if.hit) n_hit++;
            if (b_if.done) done_seen++;
            if (k == 3) check("t6_cnt_reach_max", 32'(b_if.match_cnt), CNT_ON ? 32'd3 : 32'd0);
        end
        check("t6_hits",     32'(n_hit),          32'd7);
        check("t6_cnt_sat",  32'(b_if.match_cnt), CNT_ON ? 32'd3 : 32'd0);
        check("t6_found",    32'(b_if.found),     32'd1);
        check("t6_done_cnt", 32'(done_seen),      32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
